// File: rtl/wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter
//   Round-robin arbiter sharing one Wishbone slave bus between up to 4 masters.
//   A grant is held until the owner drops m_cycle; one dead (IDLE) cycle always
//   separates successive owners. The owner's request is muxed onto the slave
//   bus and ack/readdata are routed back to it.
//
// Parameters
//   NUM_MASTERS     number of requesters (1..4)
//   ADDR_WIDTH      Wishbone address width
//   DATA_WIDTH      Wishbone data width
//   TIMEOUT_CYCLES  strobe-without-ack limit (2..255), WB_ARB_TIMEOUT_EN only
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   m_address/m_writedata       per-master request payload, master i at slice i
//   m_write/m_strobe/m_cycle    per-master Wishbone controls
//   m_ack                       per-master acknowledge (owner's bit only)
//   m_readdata                  read data broadcast to all masters
//   grant                       registered one-hot owner vector
//   s_address..s_cycle          slave-side request, taken from the owner
//   s_readdata, s_ack           slave response
//   timeout_err                 one-cycle pulse when a transfer is aborted
//
// Configuration macro
//   WB_ARB_TIMEOUT_EN           enables the strobe-without-ack watchdog
// -----------------------------------------------------------------------------
module wb_master_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS-1:0]            m_strobe,
    input  logic [NUM_MASTERS-1:0]            m_cycle,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic [DATA_WIDTH-1:0]             s_writedata,
    output logic                              s_write,
    output logic                              s_strobe,
    output logic                              s_cycle,
    input  logic [DATA_WIDTH-1:0]             s_readdata,
    input  logic                              s_ack,
    output logic                              timeout_err
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS == 0 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("wb_master_arbiter: illegal parameter value");
    end

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_owner;

    logic [NUM_MASTERS-1:0] w_pick_oh;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_found;
    logic                   w_stb_own;
    logic                   w_cyc_own;
    logic                   w_timeout;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        logic [IDX_W:0] v_sum;
        w_pick_oh  = '0;
        w_pick_idx = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (v_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
                v_sum = v_sum - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!w_found && m_cycle[v_sum[IDX_W-1:0]]) begin
                w_found                       = 1'b1;
                w_pick_idx                    = v_sum[IDX_W-1:0];
                w_pick_oh[v_sum[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

    // Ownership FSM: grant held until the owner drops cycle, then one IDLE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick_oh;
                        r_owner <= w_pick_idx;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!m_cycle[r_owner]) begin
                        r_grant  <= '0;
                        r_rr_ptr <= (r_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave mux: owner's request ANDed with grant, all zero when nobody owns.
    always_comb begin
        s_address   = '0;
        s_writedata = '0;
        s_write     = 1'b0;
        s_cycle     = 1'b0;
        w_stb_own   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_address   = s_address   | (m_address[i*ADDR_WIDTH +: ADDR_WIDTH]   & {ADDR_WIDTH{r_grant[i]}});
            s_writedata = s_writedata | (m_writedata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
            s_write     = s_write     | (m_write[i]  & r_grant[i]);
            s_cycle     = s_cycle     | (m_cycle[i]  & r_grant[i]);
            w_stb_own   = w_stb_own   | (m_strobe[i] & r_grant[i]);
        end
    end

    assign w_cyc_own = |(m_cycle & r_grant);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive strobed cycle without an ack.
    assign w_timeout = (r_state == ST_OWN) && w_stb_own && !s_ack &&
                       (r_to_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_OWN || !w_cyc_own || s_ack || w_timeout) begin
            r_to_cnt <= '0;
        end else if (w_stb_own) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign s_strobe    = w_stb_own & ~w_timeout;
    assign grant       = r_grant;
    assign timeout_err = w_timeout;

    // Acks after the owner has dropped cycle are discarded.
    assign m_ack = w_timeout ? r_grant : ({NUM_MASTERS{s_ack}} & r_grant & m_cycle);

    assign m_readdata = w_timeout ? DATA_WIDTH'(16'hDEAD)
                                  : ((|r_grant) ? s_readdata : '0);

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

    logic        clk;
    logic        reset;
    logic [63:0] m_address;
    logic [63:0] m_writedata;
    logic [3:0]  m_write;
    logic [3:0]  m_strobe;
    logic [3:0]  m_cycle;
    logic [3:0]  m_ack;
    logic [15:0] m_readdata;
    logic [3:0]  grant;
    logic [15:0] s_address;
    logic [15:0] s_writedata;
    logic        s_write;
    logic        s_strobe;
    logic        s_cycle;
    logic [15:0] s_readdata;
    logic        s_ack;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_master_arbiter #(
        .NUM_MASTERS   (4),
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_address  (m_address),
        .m_writedata(m_writedata),
        .m_write    (m_write),
        .m_strobe   (m_strobe),
        .m_cycle    (m_cycle),
        .m_ack      (m_ack),
        .m_readdata (m_readdata),
        .grant      (grant),
        .s_address  (s_address),
        .s_writedata(s_writedata),
        .s_write    (s_write),
        .s_strobe   (s_strobe),
        .s_cycle    (s_cycle),
        .s_readdata (s_readdata),
        .s_ack      (s_ack),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic        ack;
        logic [15:0] rd;
        logic [3:0]  grant;
        logic [3:0]  mack;
        logic        scyc;
        logic        sstb;
        logic [15:0] saddr;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;

        // Round-robin sweep from reset, then a single m1 read and a stray ack.
        vecs[0]  = '{4'hF, 4'hF, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{4'hF, 4'hF, 1'b1, 16'h1111, 4'h1, 4'h1, 1'b1, 1'b1, 16'h1000, 16'h1111};
        vecs[2]  = '{4'hE, 4'hE, 1'b0, 16'h0000, 4'h1, 4'h0, 1'b0, 1'b0, 16'h1000, 16'h0000};
        vecs[3]  = '{4'hE, 4'hE, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[4]  = '{4'hE, 4'hE, 1'b1, 16'h2222, 4'h2, 4'h2, 1'b1, 1'b1, 16'h0040, 16'h2222};
        vecs[5]  = '{4'hC, 4'hC, 1'b0, 16'h0000, 4'h2, 4'h0, 1'b0, 1'b0, 16'h0040, 16'h0000};
        vecs[6]  = '{4'hC, 4'hC, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[7]  = '{4'hC, 4'hC, 1'b1, 16'h3333, 4'h4, 4'h4, 1'b1, 1'b1, 16'h2000, 16'h3333};
        vecs[8]  = '{4'h8, 4'h8, 1'b0, 16'h0000, 4'h4, 4'h0, 1'b0, 1'b0, 16'h2000, 16'h0000};
        vecs[9]  = '{4'h8, 4'h8, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[10] = '{4'h8, 4'h8, 1'b1, 16'h4444, 4'h8, 4'h8, 1'b1, 1'b1, 16'h3000, 16'h4444};
        vecs[11] = '{4'h1, 4'h1, 1'b0, 16'h0000, 4'h8, 4'h0, 1'b0, 1'b0, 16'h3000, 16'h0000};
        vecs[12] = '{4'h1, 4'h1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[13] = '{4'h1, 4'h1, 1'b0, 16'h0000, 4'h1, 4'h0, 1'b1, 1'b1, 16'h1000, 16'h0000};
        vecs[14] = '{4'h0, 4'h0, 1'b0, 16'h0000, 4'h1, 4'h0, 1'b0, 1'b0, 16'h1000, 16'h0000};
        vecs[15] = '{4'h2, 4'h2, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[16] = '{4'h2, 4'h2, 1'b0, 16'h0000, 4'h2, 4'h0, 1'b1, 1'b1, 16'h0040, 16'h0000};
        vecs[17] = '{4'h2, 4'h2, 1'b1, 16'h1234, 4'h2, 4'h2, 1'b1, 1'b1, 16'h0040, 16'h1234};
        vecs[18] = '{4'h0, 4'h0, 1'b0, 16'h0000, 4'h2, 4'h0, 1'b0, 1'b0, 16'h0040, 16'h0000};
        vecs[19] = '{4'h0, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[20] = '{4'h0, 4'h0, 1'b1, 16'hBEEF, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};

        m_address   = {16'h3000, 16'h2000, 16'h0040, 16'h1000};
        m_writedata = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        m_write     = 4'h0;
        m_strobe    = 4'hF;
        m_cycle     = 4'hF;
        s_ack       = 1'b1;
        s_readdata  = 16'h5A5A;
        reset       = 1'b0;

        // Reset held with every master requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("reset grant",    32'(grant),       32'h0);
        chk("reset s_cycle",  32'(s_cycle),     32'h0);
        chk("reset s_strobe", 32'(s_strobe),    32'h0);
        chk("reset m_ack",    32'(m_ack),       32'h0);
        chk("reset rdata",    32'(m_readdata),  32'h0);
        chk("reset tmo",      32'(timeout_err), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            m_cycle    = vecs[i].cyc;
            m_strobe   = vecs[i].stb;
            s_ack      = vecs[i].ack;
            s_readdata = vecs[i].rd;
            #2;
            chk($sformatf("vec%0d grant", i),    32'(grant),      32'(vecs[i].grant));
            chk($sformatf("vec%0d m_ack", i),    32'(m_ack),      32'(vecs[i].mack));
            chk($sformatf("vec%0d s_cycle", i),  32'(s_cycle),    32'(vecs[i].scyc));
            chk($sformatf("vec%0d s_strobe", i), 32'(s_strobe),   32'(vecs[i].sstb));
            chk($sformatf("vec%0d s_addr", i),   32'(s_address),  32'(vecs[i].saddr));
            chk($sformatf("vec%0d rdata", i),    32'(m_readdata), 32'(vecs[i].rdata));
            tick();
        end
        s_ack      = 1'b0;
        s_readdata = 16'h0000;

        // Burst lock: m0 writes three beats while m2 waits (pointer at 2, only m0 asks).
        m_cycle  = 4'b0001;
        m_strobe = 4'b0001;
        m_write  = 4'b0001;
        tick();
        chk("burst grant m0", 32'(grant), 32'h1);
        m_cycle = 4'b0101;
        for (int b = 1; b <= 3; b++) begin
            m_writedata[15:0] = 16'(16'hA000 + b);
            s_ack = 1'b1;
            #1;
            chk($sformatf("burst%0d grant", b),  32'(grant),       32'h1);
            chk($sformatf("burst%0d m_ack", b),  32'(m_ack),       32'h1);
            chk($sformatf("burst%0d wdata", b),  32'(s_writedata), 32'(16'hA000 + b));
            chk($sformatf("burst%0d s_write", b), 32'(s_write),    32'h1);
            tick();
        end
        s_ack    = 1'b0;
        m_cycle  = 4'b0100;
        m_strobe = 4'b0000;
        m_write  = 4'b0000;
        #1;
        chk("burst drop grant", 32'(grant), 32'h1);
        tick();
        chk("burst dead cycle", 32'(grant), 32'h0);
        tick();
        chk("burst m2 grant",   32'(grant), 32'h4);
        m_cycle = 4'b0000;
        tick();
        tick();

        // Late ack: m3 drops cycle with a strobe pending, ack arrives in IDLE.
        m_cycle  = 4'b1000;
        m_strobe = 4'b1000;
        tick();
        chk("late m3 grant", 32'(grant), 32'h8);
        tick();
        m_cycle  = 4'b0000;
        m_strobe = 4'b0000;
        tick();
        s_ack      = 1'b1;
        s_readdata = 16'h5555;
        #1;
        chk("late ack m_ack", 32'(m_ack),      32'h0);
        chk("late ack rdata", 32'(m_readdata), 32'h0);
        chk("late ack grant", 32'(grant),      32'h0);
        s_ack      = 1'b0;
        s_readdata = 16'h0000;
        tick();

        // Slave that never acks: m1 strobes continuously.
        m_cycle  = 4'b0010;
        m_strobe = 4'b0010;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 9; k++) begin
            #1;
            if (k == 8) begin
                chk("tmo m_ack",    32'(m_ack),       32'h2);
                chk("tmo rdata",    32'(m_readdata),  32'hDEAD);
                chk("tmo err",      32'(timeout_err), 32'h1);
                chk("tmo s_strobe", 32'(s_strobe),    32'h0);
            end else begin
                chk($sformatf("tmo k%0d m_ack", k), 32'(m_ack),       32'h0);
                chk($sformatf("tmo k%0d err", k),   32'(timeout_err), 32'h0);
            end
            tick();
        end
`else
        hits = 0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (m_ack != 4'h0 || timeout_err) hits++;
            tick();
        end
        chk("no timeout acks", 32'(hits), 32'h0);
`endif
        chk("hang grant held", 32'(grant),   32'h2);
        chk("hang s_cycle",    32'(s_cycle), 32'h1);

        // Asynchronous reset mid-cycle drops the slave cycle immediately.
        #2;
        reset = 1'b0;
        #1;
        chk("async rst s_cycle", 32'(s_cycle), 32'h0);
        chk("async rst grant",   32'(grant),   32'h0);
        chk("async rst m_ack",   32'(m_ack),   32'h0);
        m_cycle  = 4'b0000;
        m_strobe = 4'b0000;
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
